// File: rtl/mac_operand_sequencer_pkg.sv
// Shared definitions for the MAC operand sequencer: default widths and FSM states.
package mac_operand_sequencer_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_MAC_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_operand_sequencer_fifo.sv
// Synchronous operand-pair FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module mac_operand_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset discards whatever is buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds buffered operand pairs to the Booth MAC one per cycle, clears the
// accumulator before every vector and flags when the MAC output is final.
module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_last,
  output logic                  mac_clr,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic                  result_valid,
  output logic [CNT_WIDTH-1:0]  vec_len,
  output logic                  len_sat
);

  localparam int                   FIFO_W  = 2 * DATA_WIDTH + 1;
  localparam int                   DRN_W   = $clog2(MAC_LATENCY + 2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  seq_state_e              r_state;
  seq_state_e              w_state_nxt;
  logic                    r_mac_clr,      w_mac_clr_nxt;
  logic [DATA_WIDTH-1:0]   r_mac_a,        w_mac_a_nxt;
  logic [DATA_WIDTH-1:0]   r_mac_b,        w_mac_b_nxt;
  logic                    r_result_valid, w_result_valid_nxt;
  logic [CNT_WIDTH-1:0]    r_vec_len,      w_vec_len_nxt;
  logic                    r_len_sat,      w_len_sat_nxt;
  logic [CNT_WIDTH-1:0]    r_cnt,          w_cnt_nxt;
  logic [DRN_W-1:0]        r_drain,        w_drain_nxt;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [FIFO_W-1:0]       w_fifo_dout;
  logic                    w_fifo_last;
  logic [DATA_WIDTH-1:0]   w_fifo_a;
  logic [DATA_WIDTH-1:0]   w_fifo_b;

  // Ready is held low during reset so nothing is accepted into a clearing FIFO.
  assign in_ready    = !w_full && !rst;
  assign w_push      = in_valid && in_ready;
  assign w_fifo_last = w_fifo_dout[FIFO_W-1];
  assign w_fifo_a    = w_fifo_dout[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_fifo_b    = w_fifo_dout[DATA_WIDTH-1:0];

  mac_operand_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({in_last, in_a, in_b}),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Next-state and next-output decode; MAC operands default to zero so idle
  // and bubble cycles add nothing to the accumulator.
  always_comb begin
    w_state_nxt        = r_state;
    w_mac_clr_nxt      = 1'b0;
    w_mac_a_nxt        = '0;
    w_mac_b_nxt        = '0;
    w_result_valid_nxt = 1'b0;
    w_vec_len_nxt      = r_vec_len;
    w_len_sat_nxt      = r_len_sat;
    w_cnt_nxt          = r_cnt;
    w_drain_nxt        = r_drain;
    w_pop              = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) w_state_nxt = ST_CLEAR;
        else          w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        w_mac_clr_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ST_STREAM;
      end
      ST_STREAM: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_mac_a_nxt = w_fifo_a;
          w_mac_b_nxt = w_fifo_b;
          if (r_cnt == CNT_MAX) w_len_sat_nxt = 1'b1;
          else                  w_cnt_nxt     = r_cnt + CNT_WIDTH'(1);
          if (w_fifo_last) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRN_W'(MAC_LATENCY);
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end else begin
          w_state_nxt = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (r_drain == '0) begin
          w_result_valid_nxt = 1'b1;
          w_vec_len_nxt      = r_cnt;
          if (w_empty) w_state_nxt = ST_IDLE;
          else         w_state_nxt = ST_CLEAR;
        end else begin
          w_drain_nxt = r_drain - DRN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset holds the MAC in clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_mac_clr      <= 1'b1;
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_result_valid <= 1'b0;
      r_vec_len      <= '0;
      r_len_sat      <= 1'b0;
      r_cnt          <= '0;
      r_drain        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_mac_clr      <= w_mac_clr_nxt;
      r_mac_a        <= w_mac_a_nxt;
      r_mac_b        <= w_mac_b_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_vec_len      <= w_vec_len_nxt;
      r_len_sat      <= w_len_sat_nxt;
      r_cnt          <= w_cnt_nxt;
      r_drain        <= w_drain_nxt;
    end
  end

  assign mac_clr      = r_mac_clr;
  assign mac_a        = r_mac_a;
  assign mac_b        = r_mac_b;
  assign result_valid = r_result_valid;
  assign vec_len      = r_vec_len;
  assign len_sat      = r_len_sat;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench: table-driven vectors, hand-timed corner sequences and
// random vectors, checked against a dot-product model and a behavioural MAC.
module tb_mac_operand_sequencer;

  typedef struct packed {
    logic [3:0]        n;
    logic [7:0][15:0]  a;
    logic [7:0][15:0]  b;
    logic [31:0]       sum;
    logic [7:0]        len;
  } vec_t;

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  len;
    logic        sat;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid, in_ready, in_last, mac_clr, result_valid, len_sat;
  logic [15:0] in_a, in_b, mac_a, mac_b;
  logic [7:0]  vec_len;
  logic in_valid2, in_ready2, in_last2, mac_clr2, result_valid2, len_sat2;
  logic [15:0] in_a2, in_b2, mac_a2, mac_b2;
  logic [1:0]  vec_len2;

  logic signed [31:0] acc, acc2;
  int   checks = 0;
  int   errors = 0;
  int   clr_cnt [2];
  exp_t q0 [$];
  exp_t q1 [$];
  vec_t tbl [7];

  mac_operand_sequencer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(8), .MAC_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .result_valid(result_valid), .vec_len(vec_len), .len_sat(len_sat)
  );

  mac_operand_sequencer #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(2), .MAC_LATENCY(1)) u_dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2),
    .in_last(in_last2), .mac_clr(mac_clr2), .mac_a(mac_a2), .mac_b(mac_b2),
    .result_valid(result_valid2), .vec_len(vec_len2), .len_sat(len_sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural radix-4 Booth MAC stand-in: one-cycle accumulate, clear on rst.
  always @(posedge clk) begin
    if (mac_clr)  acc  <= 32'sd0;
    else          acc  <= acc  + 32'($signed(mac_a))  * 32'($signed(mac_b));
    if (mac_clr2) acc2 <= 32'sd0;
    else          acc2 <= acc2 + 32'($signed(mac_a2)) * 32'($signed(mac_b2));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  task automatic mon(input int sel, input logic clr, input logic [15:0] a, input logic [15:0] b,
                     input logic rv, input logic [31:0] ac, input logic [7:0] len, input logic sat);
    exp_t e;
    if (clr) clr_cnt[sel]++;
    if (a != 16'd0 || b != 16'd0)
      chk("clear_before_data", (clr_cnt[sel] != 0) ? 32'd1 : 32'd0, 32'd1);
    if (rv) begin
      chk("clear_cycles_per_vector", clr_cnt[sel], 32'd1);
      clr_cnt[sel] = 0;
      if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: dut %0d got result_valid=1, expected no result", sel);
      end else begin
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk("mac_out_at_result", ac, e.sum);
        chk("vec_len", {24'd0, len}, {24'd0, e.len});
        chk("len_sat", {31'd0, sat}, {31'd0, e.sat});
      end
    end
  endtask

  // Result and ordering monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      clr_cnt[0] = 0;
      clr_cnt[1] = 0;
    end else begin
      mon(0, mac_clr,  mac_a,  mac_b,  result_valid,  acc,  vec_len,           len_sat);
      mon(1, mac_clr2, mac_a2, mac_b2, result_valid2, acc2, {6'd0, vec_len2}, len_sat2);
    end
  end

  task automatic expect_vec(input int sel, input logic [31:0] s, input logic [7:0] l, input logic sat);
    exp_t e;
    e.sum = s; e.len = l; e.sat = sat;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_pair(input int sel, input logic [15:0] a, input logic [15:0] b, input logic last);
    int w = 0;
    if (sel == 0) begin in_valid = 1'b1; in_a = a; in_b = b; in_last = last; end
    else          begin in_valid2 = 1'b1; in_a2 = a; in_b2 = b; in_last2 = last; end
    while (!((sel == 0) ? in_ready : in_ready2) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: dut %0d in_ready stayed 0 for %0d cycles, expected 1", sel, w);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    if (sel == 0) in_valid = 1'b0;
    else          in_valid2 = 1'b0;
  endtask

  task automatic send_vec(input int sel, input int n, input logic [7:0][15:0] va,
                          input logic [7:0][15:0] vb, input logic [31:0] es,
                          input logic [7:0] el, input logic esat, input int gapmax);
    expect_vec(sel, es, el, esat);
    for (int i = 0; i < n; i++) begin
      push_pair(sel, va[i], vb[i], (i == n - 1));
      if (gapmax > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, gapmax)) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: %0d results still pending, expected 0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Reference dot product with plain wide arithmetic, wrapped to the MAC width.
  function automatic logic [31:0] dot(input int n, input logic [7:0][15:0] va, input logic [7:0][15:0] vb);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'($signed(va[i])) * longint'($signed(vb[i]));
    return s[31:0];
  endfunction

  function automatic vec_t mk(input int n, input int a0, input int b0, input int a1, input int b1,
                              input int a2, input int b2, input longint s, input int l);
    vec_t v;
    v = '0;
    v.n = n[3:0];
    v.a[0] = a0[15:0]; v.b[0] = b0[15:0];
    v.a[1] = a1[15:0]; v.b[1] = b1[15:0];
    v.a[2] = a2[15:0]; v.b[2] = b2[15:0];
    v.sum = s[31:0];
    v.len = l[7:0];
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][15:0] va, vb;
    logic [31:0]      r;
    int               ea [6] = '{0, 0, 15, 10, 0, 0};
    int               eb [6] = '{0, 0, 5, 29, 0, 0};
    logic [5:0]       eclr = 6'b000010;
    logic [5:0]       erv  = 6'b100000;
    int               fa [6] = '{7, 15, 1, 3, 5, -7};
    int               fb [6] = '{5, 5, 2, 4, 6, 8};
    int               lat;
    int               n;

    tbl[0] = mk(2, 15, 5, 10, 29, 0, 0, 365, 2);
    tbl[1] = mk(3, 3, -2, -6, 6, -2, -2, -38, 3);
    tbl[2] = mk(1, 7, 5, 0, 0, 0, 0, 35, 1);
    tbl[3] = mk(1, 15, 5, 0, 0, 0, 0, 75, 1);
    tbl[4] = mk(1, -32768, -32768, 0, 0, 0, 0, 1073741824, 1);
    tbl[5] = mk(2, 32767, -32768, 1, 1, 0, 0, -1073709055, 2);
    tbl[6] = mk(3, 0, 123, -1, -1, 0, 0, 1, 3);

    in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; in_last = 1'b0;
    in_valid2 = 1'b0; in_a2 = 16'd0; in_b2 = 16'd0; in_last2 = 1'b0;
    rst = 1'b1;

    // Reset values while rst is held.
    repeat (3) @(negedge clk);
    chk("rst_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("rst_mac_a", {16'd0, mac_a}, 32'd0);
    chk("rst_mac_b", {16'd0, mac_b}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_vec_len", {24'd0, vec_len}, 32'd0);
    chk("rst_len_sat", {31'd0, len_sat}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_len_sat_small", {31'd0, len_sat2}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_mac_clr", {31'd0, mac_clr}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Cycle-exact trace of a two-pair vector from idle.
    send_vec(0, 2, tbl[0].a, tbl[0].b, tbl[0].sum, tbl[0].len, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("trace_mac_clr", {31'd0, mac_clr}, {31'd0, eclr[k]});
      chk("trace_mac_a", {16'd0, mac_a}, {16'd0, ea[k][15:0]});
      chk("trace_mac_b", {16'd0, mac_b}, {16'd0, eb[k][15:0]});
      chk("trace_result_valid", {31'd0, result_valid}, {31'd0, erv[k]});
    end
    wait_idle();

    // Single-pair latency: result_valid 5 edges after the push edge.
    va = '0; vb = '0; va[0] = 16'd4; vb[0] = 16'hFFFD;
    send_vec(0, 1, va, vb, 32'hFFFF_FFF4, 8'd1, 1'b0, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = k;
        break;
      end
    end
    chk("single_pair_latency", lat, 32'd5);
    wait_idle();

    // Table-driven vectors, pushed back to back.
    for (int i = 0; i < 7; i++)
      send_vec(0, int'(tbl[i].n), tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].len, 1'b0, 0);
    wait_idle();

    // One-pair vectors every cycle: FIFO fills after the fifth accepted push.
    for (int i = 0; i < 6; i++) begin
      va = '0; vb = '0;
      va[0] = fa[i][15:0];
      vb[0] = fb[i][15:0];
      r = fa[i] * fb[i];
      send_vec(0, 1, va, vb, r, 8'd1, 1'b0, 0);
      if (i == 3) chk("in_ready_three_held", {31'd0, in_ready}, 32'd1);
      if (i == 4) chk("in_ready_four_held", {31'd0, in_ready}, 32'd0);
    end
    wait_idle();

    // Three-cycle in_valid gap mid-vector produces a zero bubble.
    expect_vec(0, 32'd5, 8'd2, 1'b0);
    push_pair(0, 16'd1, 16'd1, 1'b0);
    @(negedge clk); chk("gap_idle_a", {16'd0, mac_a}, 32'd0);
    @(negedge clk); chk("gap_clear", {31'd0, mac_clr}, 32'd1);
    @(negedge clk); chk("gap_first_a", {16'd0, mac_a}, 32'd1);
    push_pair(0, 16'd2, 16'd2, 1'b1);
    chk("gap_bubble_a", {16'd0, mac_a}, 32'd0);
    chk("gap_bubble_b", {16'd0, mac_b}, 32'd0);
    @(negedge clk); chk("gap_second_a", {16'd0, mac_a}, 32'd2);
    wait_idle();

    // Reset mid-vector with three pairs still buffered.
    push_pair(0, 16'd1, 16'd1, 1'b0);
    push_pair(0, 16'd2, 16'd2, 1'b0);
    push_pair(0, 16'd3, 16'd3, 1'b0);
    push_pair(0, 16'd4, 16'd4, 1'b0);
    chk("abort_streaming_a", {16'd0, mac_a}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("abort_mac_a", {16'd0, mac_a}, 32'd0);
    chk("abort_mac_b", {16'd0, mac_b}, 32'd0);
    chk("abort_result_valid", {31'd0, result_valid}, 32'd0);
    chk("abort_vec_len", {24'd0, vec_len}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    va = '0; vb = '0; va[0] = 16'd2; vb[0] = 16'd2;
    send_vec(0, 1, va, vb, 32'd4, 8'd1, 1'b0, 0);
    wait_idle();

    // Two-bit counter: five-pair vector saturates and the flag is sticky.
    va = '0; vb = '0;
    for (int i = 0; i < 5; i++) begin va[i] = 16'd1; vb[i] = 16'd1; end
    send_vec(1, 5, va, vb, 32'd5, 8'd3, 1'b1, 0);
    wait_idle();
    send_vec(1, 1, va, vb, 32'd1, 8'd1, 1'b1, 0);
    wait_idle();

    // Random vectors with random gaps against the dot-product model.
    for (int v = 0; v < 40; v++) begin
      n = int'($urandom_range(1, 6));
      va = '0; vb = '0;
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        if (v % 3 == 0) begin
          va[i] = {{8{r[7]}}, r[7:0]};
          vb[i] = {{8{r[15]}}, r[15:8]};
        end else begin
          va[i] = r[15:0];
          vb[i] = r[31:16];
        end
      end
      send_vec(0, n, va, vb, dot(n, va, vb), n[7:0], 1'b0, 3);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Upstream feeder for the radix-4 Booth MAC. Accepts signed operand pairs on a valid/ready stream, with a last flag marking the end of each dot-product vector, and buffers them in a small FIFO. Before each vector it pulses the MAC's clear (drives the MAC rst). It then presents one pair per cycle on the MAC a/b inputs and signals when the accumulated result on the MAC out port is final. The MAC has no enable, so idle and bubble cycles drive a=b=0; a zero product leaves the accumulator unchanged.

Parameters:
DATA_WIDTH, 16, operand width; matches MAC DATA_WIDTH
FIFO_DEPTH, 4, operand-pair buffer entries; power of two, at least 2
CNT_WIDTH, 8, width of the per-vector pair counter
MAC_LATENCY, 1, clocks from a/b presented until MAC out includes that product

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full
in_a  in  DATA_WIDTH  operand A, two's complement
in_b  in  DATA_WIDTH  operand B, two's complement
in_last  in  1  pair is the final element of its vector
mac_clr  out  1  connects to MAC rst; clears the accumulator
mac_a  out  DATA_WIDTH  to MAC a
mac_b  out  DATA_WIDTH  to MAC b
result_valid  out  1  one-cycle pulse: MAC out holds the completed dot product
vec_len  out  CNT_WIDTH  pairs in the just-completed vector; valid with result_valid
len_sat  out  1  sticky flag: a vector exceeded 2^CNT_WIDTH-1 pairs

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: mac_clr=1, mac_a=0, mac_b=0, result_valid=0, vec_len=0, len_sat=0; FIFO empty; in_ready=0 while rst is high. After rst deasserts, mac_clr=0 on the first edge.
- Outputs: all are registered, except in_ready, which is combinational from the FIFO full flag.
- Push: occurs when in_valid && in_ready. In the same cycle a pop frees a slot only on the next cycle; there is no full-FIFO pass-through.
- FSM states (localparam encoded): IDLE, CLEAR, STREAM, DRAIN.
- IDLE: mac_a/mac_b=0. If the FIFO is non-empty, go to CLEAR.
- CLEAR (exactly 1 cycle): mac_clr=1, mac_a/mac_b=0, counter reset to 0. Go to STREAM.
- STREAM, FIFO non-empty: pop one pair, register it onto mac_a/mac_b, increment the counter. The counter saturates at all-ones and sets len_sat.
- STREAM, FIFO empty: bubble. Drive mac_a/mac_b=0, no count, stay in STREAM.
- STREAM, popped pair has last=1: go to DRAIN with the drain counter = MAC_LATENCY.
- DRAIN: mac_a/mac_b=0. Decrement the drain counter each cycle. At 0: pulse result_valid for 1 cycle, load vec_len from the counter, go to CLEAR if the FIFO is non-empty, else IDLE.
- Latency: a one-pair vector pushed into an empty idle block gives result_valid 4+MAC_LATENCY edges after the push edge.
- Back-to-back vectors: exactly one CLEAR cycle separates vectors. The FIFO keeps accepting during DRAIN and CLEAR.
- No mixing: the first pair of a new vector is never presented before mac_clr for that vector.
- Arithmetic: operands pass through unmodified; the block performs no sign handling.
- Mid-operation reset: everything returns to reset values asynchronously. Buffered pairs are discarded and no result_valid is produced for the aborted vector.
- len_sat: cleared only by rst.

Decomposition:
- Shared header file mac_defs.vh: FSM state localparams and default widths, shared with the MAC and its testbench.
- Sub-module mac_operand_fifo: synchronous FIFO, DATA_WIDTH*2+1 bits wide, FIFO_DEPTH entries. Provides push, pop, full, empty, dout. Pointers carry an extra wrap bit for full/empty detection.

Test Plan:
- Single vector (15,5),(10,29) last on the 2nd pair → mac_clr pulse, then a/b=15/5 and 10/29 on consecutive cycles; result_valid with MAC out=365, vec_len=2.
- Signed vector (3,-2),(-6,6),(-2,-2) → MAC out = -6-36+4 = -38 = 0xFFFFFFDA at result_valid; vec_len=3.
- Back-to-back vectors (7,5)last then (15,5)last pushed every cycle → results 35 then 75. Exactly one mac_clr cycle between them; in_ready falls when 4 entries are held.
- in_valid gap of 3 cycles mid-vector (1,1),gap,(2,2)last → a/b=0 during the gap; result 5, vec_len=2.
- Assert rst while STREAM holds 3 buffered pairs → outputs return to reset values immediately, no result_valid; a subsequent vector (2,2)last gives 4.
- CNT_WIDTH=2, vector of 5 pairs (1,1) → vec_len=3, len_sat=1, MAC out=5.
